// File: rtl/pipe_if_fetch.sv
// pipe_if_fetch
//   Instruction-fetch stage feeding the IF/ID register. Owns the PC, issues
//   fetches over a req/ready handshake (data returns in the accepting cycle),
//   honours the IF/ID stall/branch controls and discards fetches that were
//   already in flight when a redirect arrived.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   PC_STEP   sequential PC increment in bytes
//
// Ports
//   in_clk, in_rst_n          clock (rising edge), async active-low reset
//   in_stall                  downstream hold, instruction not consumed
//   in_branch, in_target      single-cycle redirect and its target PC
//   out_imem_req/addr         fetch request and address
//   in_imem_ready/rdata       memory accept and same-cycle instruction word
//   out_valid/npc/instruction delivered instruction (NOP when not valid)
//   out_misalign              only with IF_ALIGN_CHECK_EN: last redirect
//                             target was not word aligned, fetching stopped
//
// Configuration
//   IF_ALIGN_CHECK_EN  when defined, misaligned redirect targets park the
//                      stage and raise out_misalign; when undefined the low
//                      two target bits are ignored.
module pipe_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_stall,
  input  logic        in_branch,
  input  logic [31:0] in_target,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ready,
  input  logic [31:0] in_imem_rdata,
`ifdef IF_ALIGN_CHECK_EN
  output logic        out_misalign,
`endif
  output logic        out_valid,
  output logic [31:0] out_npc,
  output logic [31:0] out_instruction
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DROP  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;  // parked after a misaligned redirect

  logic [2:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] req_addr_r;
  logic [31:0] buf_r;
  logic [31:0] buf_npc_r;

  logic [31:0] target_s;
  logic [31:0] step_npc_s;
  logic        fetch_hit_s;
  logic        hold_out_s;
  logic [2:0]  redir_state_s;   // destination of a redirect with no request pending
  logic [2:0]  drop_done_s;     // destination once the discarded fetch completes

`ifdef IF_ALIGN_CHECK_EN
  logic mis_r;
  logic misaligned_s;
`endif

  // Redirect target qualification and post-redirect destinations
  always_comb begin
`ifdef IF_ALIGN_CHECK_EN
    target_s      = in_target;
    misaligned_s  = (in_target[1:0] != 2'b00);
    redir_state_s = misaligned_s ? S_IDLE : S_FETCH;
    drop_done_s   = mis_r ? S_IDLE : S_FETCH;
`else
    // Low bits are architecturally ignored without the alignment check.
    target_s      = in_target & ~32'd3;
    redir_state_s = S_FETCH;
    drop_done_s   = S_FETCH;
`endif
  end

  // Output decode: a fetch hit is forwarded straight from memory, a held
  // instruction comes from the buffer, anything else is a NOP bubble.
  always_comb begin
    step_npc_s    = req_addr_r + PC_STEP;
    fetch_hit_s   = (state_r == S_FETCH) && in_imem_ready && !in_branch;
    hold_out_s    = (state_r == S_HOLD) && !in_branch;
    out_imem_req  = (state_r == S_FETCH) || (state_r == S_DROP);
    out_imem_addr = req_addr_r;
    if (fetch_hit_s) begin
      out_valid       = 1'b1;
      out_instruction = in_imem_rdata;
      out_npc         = step_npc_s;
    end else if (hold_out_s) begin
      out_valid       = 1'b1;
      out_instruction = buf_r;
      out_npc         = buf_npc_r;
    end else begin
      out_valid       = 1'b0;
      out_instruction = 32'h0000_0000;
      out_npc         = 32'h0000_0000;
    end
  end

  // Fetch state machine, PC and instruction buffer
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r    <= S_BOOT;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      buf_r      <= 32'h0000_0000;
      buf_npc_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_BOOT: begin
          if (in_branch) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
            state_r    <= redir_state_s;
          end else begin
            req_addr_r <= pc_r;
            state_r    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_branch) begin
            pc_r <= target_s;
            if (in_imem_ready) begin
              req_addr_r <= target_s;
              state_r    <= redir_state_s;
            end else begin
              // Request must complete at its old address; discard it later.
              state_r <= S_DROP;
            end
          end else if (in_imem_ready) begin
            if (in_stall) begin
              buf_r     <= in_imem_rdata;
              buf_npc_r <= step_npc_s;
              state_r   <= S_HOLD;
            end else begin
              pc_r       <= step_npc_s;
              req_addr_r <= step_npc_s;
              state_r    <= S_FETCH;
            end
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (in_branch) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
            state_r    <= redir_state_s;
          end else if (!in_stall) begin
            pc_r       <= buf_npc_r;
            req_addr_r <= buf_npc_r;
            state_r    <= S_FETCH;
          end else begin
            state_r <= S_HOLD;
          end
        end
        S_DROP: begin
          if (in_branch) begin
            pc_r <= target_s;
            if (in_imem_ready) begin
              // Stale fetch finishes now; resume straight at the newest target.
              req_addr_r <= target_s;
              state_r    <= redir_state_s;
            end else begin
              state_r <= S_DROP;
            end
          end else if (in_imem_ready) begin
            req_addr_r <= pc_r;
            state_r    <= drop_done_s;
          end else begin
            state_r <= S_DROP;
          end
        end
        S_IDLE: begin
          if (in_branch) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
            state_r    <= redir_state_s;
          end else begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_BOOT;
        end
      endcase
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // Misalignment flag: every redirect re-evaluates it, reset clears it
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      mis_r <= 1'b0;
    end else if (in_branch) begin
      mis_r <= misaligned_s;
    end else begin
      mis_r <= mis_r;
    end
  end

  assign out_misalign = mis_r;
`endif

endmodule

// File: doc/pipe_if_fetch.md
Name: pipe_if_fetch

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register; owns the PC.
- Issues requests to instruction memory over a req/ready handshake.
- Presents out_npc/out_instruction for IF/ID to capture.
- Honours the same in_stall/in_branch controls that drive IF/ID; branch redirect loads a new PC, and in-flight fetches from the old path are discarded.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
in_clk  input  1  clock, rising edge.
in_rst_n  input  1  reset, asynchronous, active-low.
in_stall  input  1  downstream stall; IF/ID holds and the current instruction is not consumed.
in_branch  input  1  redirect request (taken branch/jump), single-cycle pulse.
in_target  input  32  redirect PC, sampled when in_branch=1.
out_imem_req  output  1  fetch request valid.
out_imem_addr  output  32  fetch address; stable while out_imem_req=1 and in_imem_ready=0.
in_imem_ready  input  1  memory accepts the request and returns data in the same cycle.
in_imem_rdata  input  32  instruction word, valid when out_imem_req & in_imem_ready.
out_valid  output  1  out_instruction holds a real instruction.
out_npc  output  32  PC of the delivered instruction + PC_STEP.
out_instruction  output  32  delivered instruction; 32'h0 (NOP) whenever out_valid=0.

Behaviour:
Reset, while in_rst_n=0:
- state=S_BOOT, pc=RESET_PC, req_addr=RESET_PC, buf=0, out_imem_req=0, out_valid=0, out_instruction=0, out_npc=0.

Internal registers:
- pc: next address to fetch.
- req_addr: drives out_imem_addr.
- buf/buf_npc: held instruction.
- state in {S_BOOT, S_FETCH, S_DROP, S_HOLD}.

Delivery rule: an instruction is consumed on a cycle with out_valid=1 & in_stall=0 & in_branch=0.

S_BOOT:
- Next cycle goes to S_FETCH; req_addr=pc.
- out_imem_req=0.

S_FETCH:
- out_imem_req=1, out_imem_addr=req_addr.
- in_imem_ready=1 & in_branch=0:
  - out_valid=1 combinationally; out_instruction=in_imem_rdata; out_npc=req_addr+PC_STEP.
  - If consumed: pc<=req_addr+PC_STEP, req_addr<=same, remain S_FETCH. This sustains 1 instr/cycle back-to-back.
  - If in_stall=1: buf<=rdata, buf_npc<=req_addr+PC_STEP, go S_HOLD.
- in_imem_ready=0: out_valid=0; req and address held.

S_HOLD:
- out_imem_req=0; out_valid=1, outputs come from buf/buf_npc.
- in_stall=0 (consumed): pc<=buf_npc, req_addr<=buf_npc, go S_FETCH.

S_DROP:
- out_imem_req=1 with the old req_addr until in_imem_ready=1; out_valid=0.
- On ready: data discarded, req_addr<=pc, go S_FETCH.

Redirect (in_branch=1) has priority over in_stall and over delivery in every state:
- pc<=in_target; out_valid forced 0 that cycle.
- S_FETCH without ready → S_DROP. A request is never withdrawn or its address changed before ready.
- S_FETCH with ready, S_HOLD or S_BOOT → S_FETCH with req_addr<=in_target.
- S_DROP → stays S_DROP; pc updated to the latest target.

Arithmetic: PC math is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

Reset asserted mid-request: out_imem_req drops immediately (asynchronous); all state returns to reset values.

Optional Feature:
Macro IF_ALIGN_CHECK_EN.
- Defined: adds output out_misalign (1 bit).
  - A redirect with in_target[1:0]!=0 sets out_misalign=1 and enters S_HOLD-like idle: no request, out_valid=0.
  - Cleared only by a later aligned redirect or reset.
- Undefined: no port; in_target[1:0] is ignored (forced to 00).

Test Plan:
1. Reset, RESET_PC=0, memory always ready, rdata=addr ^ 32'hA5A5_0000 → addresses 0,4,8,C on consecutive cycles; out_npc 4,8,C,10; out_valid=1 each cycle from the second cycle after reset release.
2. in_stall=1 for 3 cycles while delivering addr 8 → out_instruction=32'hA5A5_0008, out_npc=C held all 3 cycles, out_imem_req=0; fetch of C starts the cycle after stall drops.
3. Memory ready delayed 3 cycles on addr 10 → out_imem_addr=10 stable, out_valid=0, instruction=0 throughout; delivered on the 4th cycle.
4. in_branch=1, in_target=32'h100 while addr 10 is pending (ready=0) → S_DROP; addr 10 stays on the bus until ready; its data is never delivered; next request is 100, out_npc=104.
5. Redirect to 32'hFFFF_FFFC → next delivered out_npc=0, following fetch address 0.
6. (IF_ALIGN_CHECK_EN) redirect to 32'h102 → out_misalign=1, no requests; then redirect to 200 → out_misalign=0, fetch 200.
